// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    typedef enum logic [2:0] {
        BoothZero,
        BoothPosA,
        BoothPos2A,
        BoothNegA,
        BoothNeg2A
    } booth_sel_e;

    localparam int unsigned MultIters = 16;
    localparam int unsigned DivIters  = 32;

    localparam logic [4:0] AluOpMult = 5'b00110;
    localparam logic [4:0] AluOpDiv  = 5'b00111;

endpackage

// File: rtl/multdiv_booth_recode.sv
// Radix-4 Booth recoder: {b[i+1], b[i], b[i-1]} -> partial-product select.
module multdiv_booth_recode
    import multdiv_pkg::*;
(
    input  logic [2:0] bits_i,
    output booth_sel_e sel_o
);

    always_comb begin
        sel_o = BoothZero;
        unique case (bits_i)
            3'b001, 3'b010: sel_o = BoothPosA;
            3'b011:         sel_o = BoothPos2A;
            3'b100:         sel_o = BoothNeg2A;
            3'b101, 3'b110: sel_o = BoothNegA;
            default:        sel_o = BoothZero;
        endcase
    end

endmodule

// File: rtl/multdiv_iter_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (restoring) engine.
// Define MULTDIV_EARLY_OUT_EN to finish zero-operand multiplies and divide-by-zero in one cycle.
module multdiv_iter_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MULT_ITERS = MultIters,
    parameter int unsigned DIV_ITERS  = DivIters
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned W = WIDTH;

    state_e         state_q;
    logic [5:0]     cnt_q;
    logic [2*W:0]   prod_q;   // {hi, lo, booth guard bit}
    logic [2*W-1:0] rq_q;     // {remainder, quotient}
    logic [W-1:0]   opa_q;    // multiplicand, or divisor magnitude
    logic           op_div_q;
    logic           neg_q;
    logic           div0_q;

    booth_sel_e     booth_sel;
    logic [W+1:0]   add_a;
    logic [W+1:0]   add_b;
    logic [W+1:0]   sum;
    logic           sub;
    logic [2*W:0]   prod_step;
    logic [2*W-1:0] rq_step;
    logic [W-1:0]   div_rem;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic [W-1:0]   quo;
    logic [W-1:0]   done_result;
    logic           done_exc;

    multdiv_booth_recode u_booth_recode (
        .bits_i (prod_q[2:0]),
        .sel_o  (booth_sel)
    );

    // Two guard bits: hi + 2A can exceed W+1 bits before the arithmetic shift by two.
    always_comb begin
        add_a = '0;
        add_b = '0;
        sub   = 1'b0;
        if (state_q == StDiv) begin
            add_a = {1'b0, rq_q[2*W-1:W-1]};
            add_b = {2'b00, opa_q};
            sub   = 1'b1;
        end else begin
            add_a = {{2{prod_q[2*W]}}, prod_q[2*W:W+1]};
            unique case (booth_sel)
                BoothPosA:  add_b = {{2{opa_q[W-1]}}, opa_q};
                BoothPos2A: add_b = {opa_q[W-1], opa_q, 1'b0};
                BoothNegA: begin
                    add_b = {{2{opa_q[W-1]}}, opa_q};
                    sub   = 1'b1;
                end
                BoothNeg2A: begin
                    add_b = {opa_q[W-1], opa_q, 1'b0};
                    sub   = 1'b1;
                end
                default:    add_b = '0;
            endcase
        end
        sum = add_a + (sub ? ~add_b : add_b) + (W+2)'(sub);
    end

    always_comb begin
        prod_step = {sum, prod_q[W:2]};
        div_rem   = sum[W+1] ? rq_q[2*W-2:W-1] : sum[W-1:0];
        rq_step   = {div_rem, rq_q[W-2:0], ~sum[W+1]};
        abs_a     = data_operandA[W-1] ? (~data_operandA + 1'b1) : data_operandA;
        abs_b     = data_operandB[W-1] ? (~data_operandB + 1'b1) : data_operandB;
    end

    // Only a same-sign divide can produce an unrepresentable positive quotient (MIN / -1).
    always_comb begin
        quo         = rq_q[W-1:0];
        done_result = prod_q[W:1];
        done_exc    = prod_q[2*W:W+1] != {W{prod_q[W]}};
        if (op_div_q) begin
            if (div0_q) begin
                done_result = '0;
                done_exc    = 1'b1;
            end else begin
                done_result = neg_q ? (~quo + 1'b1) : quo;
                done_exc    = ~neg_q & quo[W-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            prod_q         <= '0;
            rq_q           <= '0;
            opa_q          <= '0;
            op_div_q       <= 1'b0;
            neg_q          <= 1'b0;
            div0_q         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                cnt_q    <= '0;
                op_div_q <= 1'b0;
                opa_q    <= data_operandA;
`ifdef MULTDIV_EARLY_OUT_EN
                if (data_operandA == '0 || data_operandB == '0) begin
                    prod_q  <= '0;
                    state_q <= StDone;
                end else begin
                    prod_q  <= {{W{1'b0}}, data_operandB, 1'b0};
                    state_q <= StMult;
                end
`else
                prod_q  <= {{W{1'b0}}, data_operandB, 1'b0};
                state_q <= StMult;
`endif
            end else if (ctrl_DIV) begin
                cnt_q    <= '0;
                op_div_q <= 1'b1;
                opa_q    <= abs_b;
                rq_q     <= {{W{1'b0}}, abs_a};
                neg_q    <= data_operandA[W-1] ^ data_operandB[W-1];
                div0_q   <= data_operandB == '0;
`ifdef MULTDIV_EARLY_OUT_EN
                state_q  <= (data_operandB == '0) ? StDone : StDiv;
`else
                state_q  <= StDiv;
`endif
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StMult: begin
                        prod_q <= prod_step;
                        cnt_q  <= cnt_q + 6'd1;
                        if (cnt_q == 6'(MULT_ITERS - 1)) begin
                            state_q <= StDone;
                        end
                    end
                    StDiv: begin
                        rq_q  <= rq_step;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(DIV_ITERS - 1)) begin
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        data_result    <= done_result;
                        data_exception <= done_exc;
                        data_resultRDY <= 1'b1;
                        state_q        <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iter_unit.sv
// Scoreboard bench for multdiv_iter_unit: directed cases plus randomized ops with aborts.
module tb_multdiv_iter_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    multdiv_iter_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          e0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per completion pulse.
    always @(posedge clock) begin
        #1;
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_rdy: ready pulse with no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {32'h0, data_result}, {32'h0, e.res});
                check("exception", {63'h0, data_exception}, {63'h0, e.exc});
                check("latency", 64'(cyc - e.e0), 64'(e.lat));
                last_res = e.res;
            end
        end
    end

    // Reference model: op 0 = mult, 1 = div, 2 = both pulses (mult wins).
    task automatic model(input int op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     sa;
        int     sbv;
        bit     early;
        sa  = $signed(a);
        sbv = $signed(b);
        early = 1'b0;
        if (op != 1) begin
            p = longint'(sa) * longint'(sbv);
            r = p[31:0];
            e = (p != longint'($signed(r)));
            lat = 17;
`ifdef MULTDIV_EARLY_OUT_EN
            early = (a == 0) || (b == 0);
`endif
        end else begin
            lat = 33;
            if (sbv == 0) begin
                r = 0;
                e = 1'b1;
`ifdef MULTDIV_EARLY_OUT_EN
                early = 1'b1;
`endif
            end else if (sa == 32'sh80000000 && sbv == -1) begin
                r = 32'h80000000;
                e = 1'b1;
            end else begin
                r = sa / sbv;
                e = 1'b0;
            end
        end
        if (early) lat = 1;
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        if (sb.size() > 0) sb.delete();  // pending op is aborted by this start
        model(op, a, b, e.res, e.exc, e.lat);
        e.e0 = cyc + 1;
        sb.push_back(e);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = (op != 1);
        ctrl_DIV  = (op != 0);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("rdy_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hffffffff;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'(-$signed($urandom_range(1, 20)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", {32'h0, data_result}, 64'h0);
        check("reset_exception", {63'h0, data_exception}, 64'h0);
        check("reset_rdy", {63'h0, data_resultRDY}, 64'h0);
        reset = 1'b0;

        issue(0, 32'd7, 32'hfffffffa);
        drain();
        check("hold_result", {32'h0, data_result}, {32'h0, last_res});
        issue(0, 32'h00010000, 32'h00010000);
        drain();
        issue(1, 32'hffffff9c, 32'd7);
        drain();
        issue(1, 32'd5, 32'd0);
        drain();
        issue(1, 32'h80000000, 32'hffffffff);
        drain();
        issue(2, 32'd6, 32'd3);
        drain();
        issue(0, 32'd0, 32'd12345);
        drain();

        // Abort a divide with a multiply; the divide must never complete.
        issue(1, 32'd1000, 32'd3);
        repeat (8) @(negedge clock);
        issue(0, 32'd3, 32'd4);
        repeat (40) @(negedge clock);
        drain();
        check("abort_result", {32'h0, data_result}, 64'd12);

        // Reset mid-multiply clears outputs and suppresses ready.
        issue(0, 32'd9, 32'd9);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        #1;
        check("midreset_result", {32'h0, data_result}, 64'h0);
        check("midreset_exception", {63'h0, data_exception}, 64'h0);
        check("midreset_rdy", {63'h0, data_resultRDY}, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        issue(0, 32'd2, 32'd2);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 2), pick(), pick());
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge clock);
                issue($urandom_range(0, 2), pick(), pick());
            end
            drain();
            check("hold_random", {32'h0, data_result}, {32'h0, last_res});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
